// File: rtl/seq_bus_datapath_if.sv
// Control-unit side of seq_bus_datapath: operation request (start/op/operands) and status/results.
// master = control unit, slave = datapath.
interface seq_bus_datapath_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
);
  logic              start;
  logic [2:0]        op;
  logic [REG_AW-1:0] ra;
  logic [REG_AW-1:0] rb;
  logic [REG_AW-1:0] rd;
  logic              imm_sel;
  logic [DATA_W-1:0] imm;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result_lo;
  logic [DATA_W-1:0] result_hi;

  modport master (
    output start, op, ra, rb, rd, imm_sel, imm,
    input  busy, done, result_lo, result_hi
  );

  modport slave (
    input  start, op, ra, rb, rd, imm_sel, imm,
    output busy, done, result_lo, result_hi
  );
endinterface

// File: rtl/seq_bus_datapath.sv
// Single-bus register-transfer datapath with a 3-step sequencer: Rd <= Ra op (Rb | imm).
// Accept at edge k, writeback and done at edge k+3; start is ignored (not queued) while busy.
module seq_bus_datapath #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              i_clock,
  input  logic              i_clear,
  seq_bus_datapath_if.slave ctl,
  input  logic              i_wr_en,
  input  logic [REG_AW-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [REG_AW-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data,
  output logic [DATA_W-1:0] o_bus_out
);
  localparam int NUM_REGS = 2 ** REG_AW;
  localparam int SH_W     = $clog2(DATA_W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TA   = 2'd1;
  localparam logic [1:0] S_TB   = 2'd2;
  localparam logic [1:0] S_TWB  = 2'd3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;

  logic [1:0]          r_state;
  logic [2:0]          r_op;
  logic [REG_AW-1:0]   r_ra;
  logic [REG_AW-1:0]   r_rb;
  logic [REG_AW-1:0]   r_rd;
  logic                r_imm_sel;
  logic [DATA_W-1:0]   r_imm;
  logic [DATA_W-1:0]   r_y;
  logic [2*DATA_W-1:0] r_z;
  logic [DATA_W-1:0]   r_hi;
  logic                r_done;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  logic [DATA_W-1:0]   w_rd_a;
  logic [DATA_W-1:0]   w_rd_b;
  logic [DATA_W-1:0]   w_bus;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;
  logic [2*DATA_W-1:0] w_prod;
  logic [SH_W-1:0]     w_sh;
  logic [2*DATA_W-1:0] w_alu;
  logic                w_seq_wr;

  assign w_rd_a = (r_ra == '0) ? '0 : r_regs[r_ra];
  assign w_rd_b = (r_rb == '0) ? '0 : r_regs[r_rb];

  always_comb begin
    w_bus = '0;
    case (r_state)
      S_TA:    w_bus = w_rd_a;
      S_TB:    w_bus = r_imm_sel ? r_imm : w_rd_b;
      S_TWB:   w_bus = r_z[DATA_W-1:0];
      default: w_bus = '0;
    endcase
  end

  // Bit DATA_W of the extended sum/difference is the carry/borrow carried into Z high.
  assign w_sum  = {1'b0, r_y} + {1'b0, w_bus};
  assign w_diff = {1'b0, r_y} - {1'b0, w_bus};
  assign w_prod = {{DATA_W{1'b0}}, r_y} * {{DATA_W{1'b0}}, w_bus};
  assign w_sh   = w_bus[SH_W-1:0];

  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD:  w_alu = {{(DATA_W-1){1'b0}}, w_sum};
      OP_SUB:  w_alu = {{(DATA_W-1){1'b0}}, w_diff};
      OP_AND:  w_alu = {{DATA_W{1'b0}}, r_y & w_bus};
      OP_OR:   w_alu = {{DATA_W{1'b0}}, r_y | w_bus};
      OP_SHL:  w_alu = {{DATA_W{1'b0}}, r_y << w_sh};
      OP_SHR:  w_alu = {{DATA_W{1'b0}}, r_y >> w_sh};
      OP_MUL:  w_alu = w_prod;
      default: w_alu = {{DATA_W{1'b0}}, w_bus};
    endcase
  end

  always_ff @(posedge i_clock or negedge i_clear) begin
    if (!i_clear) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_ra      <= '0;
      r_rb      <= '0;
      r_rd      <= '0;
      r_imm_sel <= 1'b0;
      r_imm     <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_hi      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ctl.start) begin
            r_op      <= ctl.op;
            r_ra      <= ctl.ra;
            r_rb      <= ctl.rb;
            r_rd      <= ctl.rd;
            r_imm_sel <= ctl.imm_sel;
            r_imm     <= ctl.imm;
            r_state   <= S_TA;
          end
        end
        S_TA: begin
          r_y     <= w_bus;
          r_state <= S_TB;
        end
        S_TB: begin
          r_z     <= w_alu;
          r_state <= S_TWB;
        end
        default: begin
          if (r_op == OP_MUL) r_hi <= r_z[2*DATA_W-1:DATA_W];
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_seq_wr = (r_state == S_TWB) && (r_rd != '0);

  // Sequencer write is issued last so it overrides an external write to the same address.
  always_ff @(posedge i_clock or negedge i_clear) begin
    if (!i_clear) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      if (i_wr_en && (i_wr_addr != '0)) r_regs[i_wr_addr] <= i_wr_data;
      if (w_seq_wr) r_regs[r_rd] <= w_bus;
    end
  end

  assign o_dbg_data    = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];
  assign o_bus_out     = w_bus;
  assign ctl.busy      = (r_state != S_IDLE);
  assign ctl.done      = r_done;
  assign ctl.result_lo = r_z[DATA_W-1:0];
  assign ctl.result_hi = r_hi;
endmodule

// File: tb/tb_seq_bus_datapath.sv
// Randomised and directed bench for seq_bus_datapath against an arithmetic reference model.
module tb_seq_bus_datapath;
  logic        clk = 1'b0;
  logic        clear;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] bus_out;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_regs [16];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] bus_log [3];
  logic        busy_log [3];

  always #5 clk = ~clk;

  seq_bus_datapath_if #(.DATA_W(32), .REG_AW(4)) bus_if ();

  seq_bus_datapath #(.DATA_W(32), .REG_AW(4)) dut (
    .i_clock   (clk),
    .i_clear   (clear),
    .ctl       (bus_if),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_dbg_addr(dbg_addr),
    .o_dbg_data(dbg_data),
    .o_bus_out (bus_out)
  );

  function automatic logic [63:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return {32'd0, a} + {32'd0, b};
      3'd1:    return {31'd0, (a < b), a - b};
      3'd2:    return {32'd0, a & b};
      3'd3:    return {32'd0, a | b};
      3'd4:    return {32'd0, a << (b % 32)};
      3'd5:    return {32'd0, a >> (b % 32)};
      3'd6:    return {32'd0, a} * {32'd0, b};
      default: return {32'd0, b};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [3:0] a, output logic [31:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  task automatic ext_write(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a != 4'd0) m_regs[a] = d;
  endtask

  task automatic set_req(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rd, input logic isel, input logic [31:0] imm);
    bus_if.op = op; bus_if.ra = ra; bus_if.rb = rb; bus_if.rd = rd;
    bus_if.imm_sel = isel; bus_if.imm = imm;
  endtask

  task automatic model_commit(input logic [2:0] op, input logic [3:0] rd, input logic [63:0] z);
    if (rd != 4'd0) m_regs[rd] = z[31:0];
    m_lo = z[31:0];
    if (op == 3'd6) m_hi = z[63:32];
  endtask

  // lat counts edges from the one that accepts start to the one after which done is seen (4 expected).
  task automatic run_op(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] rd, input logic isel, input logic [31:0] imm, output int lat);
    logic [63:0] z;
    z = ref_alu(op, m_regs[ra], isel ? imm : m_regs[rb]);
    set_req(op, ra, rb, rd, isel, imm);
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    lat = 1;
    while (!bus_if.done && lat < 12) begin
      if (lat <= 3) begin
        bus_log[lat-1]  = bus_out;
        busy_log[lat-1] = bus_if.busy;
      end
      tick();
      lat++;
    end
    if (bus_if.done) model_commit(op, rd, z);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic        saw_done;
    int          lat;
    repeat (2) tick();
    vectors++; if (bus_if.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
    vectors++; if (bus_if.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bus_if.done); end
    vectors++; if (bus_out !== 32'd0) begin miscompares++; $display("FAIL reset_bus: got %h want 0", bus_out); end
    vectors++; if (bus_if.result_lo !== 32'd0) begin miscompares++; $display("FAIL reset_lo: got %h want 0", bus_if.result_lo); end
    vectors++; if (bus_if.result_hi !== 32'd0) begin miscompares++; $display("FAIL reset_hi: got %h want 0", bus_if.result_hi); end
    clear = 1'b1;
    tick();
    ext_write(4'd1, 32'h1234);
    set_req(3'd7, 4'd0, 4'd0, 4'd2, 1'b1, 32'hAAAA);
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    tick();
    tick();
    clear = 1'b0;
    #1;
    vectors++; if (bus_if.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", bus_if.busy); end
    vectors++; if (bus_out !== 32'd0) begin miscompares++; $display("FAIL abort_bus: got %h want 0", bus_out); end
    vectors++; if (bus_if.result_lo !== 32'd0) begin miscompares++; $display("FAIL abort_lo: got %h want 0", bus_if.result_lo); end
    peek(4'd1, v);
    vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL abort_r1: got %h want 0", v); end
    saw_done = 1'b0;
    repeat (3) begin tick(); saw_done |= bus_if.done; end
    clear = 1'b1;
    for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (3) begin tick(); saw_done |= bus_if.done; end
    vectors++; if (saw_done !== 1'b0) begin miscompares++; $display("FAIL abort_done: got %b want 0", saw_done); end
    peek(4'd2, v);
    vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL abort_r2: got %h want 0", v); end
    ext_write(4'd0, 32'hDEADBEEF);
    peek(4'd0, v);
    vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL r0_ext: got %h want 0", v); end
    run_op(3'd7, 4'd0, 4'd0, 4'd0, 1'b1, 32'd5, lat);
    peek(4'd0, v);
    vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL r0_seq: got %h want 0", v); end
    vectors++; if (bus_if.result_lo !== 32'd5) begin miscompares++; $display("FAIL r0_mov_lo: got %h want 5", bus_if.result_lo); end
  endtask

  task automatic test_add_carry();
    logic [31:0] v;
    int          lat;
    ext_write(4'd1, 32'hFFFFFFFF);
    ext_write(4'd2, 32'd1);
    run_op(3'd0, 4'd1, 4'd2, 4'd3, 1'b0, 32'd0, lat);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL add_latency: got %0d want 4", lat); end
    vectors++; if (bus_log[0] !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL add_bus_ta: got %h want ffffffff", bus_log[0]); end
    vectors++; if (bus_log[1] !== 32'd1) begin miscompares++; $display("FAIL add_bus_tb: got %h want 1", bus_log[1]); end
    vectors++; if (bus_log[2] !== 32'd0) begin miscompares++; $display("FAIL add_bus_twb: got %h want 0", bus_log[2]); end
    vectors++; if ({busy_log[0], busy_log[1], busy_log[2], bus_if.busy} !== 4'b1110) begin
      miscompares++; $display("FAIL add_busy: got %b want 1110", {busy_log[0], busy_log[1], busy_log[2], bus_if.busy}); end
    peek(4'd3, v);
    vectors++; if (v !== m_regs[3]) begin miscompares++; $display("FAIL add_r3: got %h want %h", v, m_regs[3]); end
    tick();
    vectors++; if (bus_if.done !== 1'b0) begin miscompares++; $display("FAIL add_done_width: got %b want 0", bus_if.done); end
  endtask

  task automatic test_mul();
    logic [31:0] v;
    int          lat;
    ext_write(4'd1, 32'h10000);
    run_op(3'd6, 4'd1, 4'd0, 4'd4, 1'b1, 32'h30000, lat);
    peek(4'd4, v);
    vectors++; if (v !== m_regs[4]) begin miscompares++; $display("FAIL mul_r4: got %h want %h", v, m_regs[4]); end
    vectors++; if (bus_if.result_hi !== m_hi) begin miscompares++; $display("FAIL mul_hi: got %h want %h", bus_if.result_hi, m_hi); end
    vectors++; if (bus_if.result_lo !== m_lo) begin miscompares++; $display("FAIL mul_lo: got %h want %h", bus_if.result_lo, m_lo); end
    run_op(3'd0, 4'd1, 4'd1, 4'd5, 1'b0, 32'd0, lat);
    vectors++; if (bus_if.result_hi !== m_hi) begin miscompares++; $display("FAIL mul_hi_kept: got %h want %h", bus_if.result_hi, m_hi); end
  endtask

  task automatic test_shift_sub();
    logic [31:0] v;
    int          lat;
    ext_write(4'd1, 32'd1);
    run_op(3'd4, 4'd1, 4'd0, 4'd6, 1'b1, 32'd33, lat);
    peek(4'd6, v);
    vectors++; if (v !== m_regs[6]) begin miscompares++; $display("FAIL shl_mask: got %h want %h", v, m_regs[6]); end
    ext_write(4'd2, 32'd3);
    ext_write(4'd3, 32'd5);
    run_op(3'd1, 4'd2, 4'd3, 4'd7, 1'b0, 32'd0, lat);
    peek(4'd7, v);
    vectors++; if (v !== m_regs[7]) begin miscompares++; $display("FAIL sub_borrow: got %h want %h", v, m_regs[7]); end
  endtask

  task automatic test_handshake();
    logic [31:0] v;
    int          dones, last, first;
    set_req(3'd7, 4'd0, 4'd0, 4'd8, 1'b1, 32'h11);
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    tick();
    set_req(3'd7, 4'd0, 4'd0, 4'd9, 1'b1, 32'h22);
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    dones = 0;
    repeat (12) begin tick(); if (bus_if.done) dones++; end
    m_regs[8] = 32'h11; m_lo = 32'h11;
    vectors++; if (dones !== 1) begin miscompares++; $display("FAIL tb_start_ignored: got %0d dones want 1", dones); end
    peek(4'd9, v);
    vectors++; if (v !== m_regs[9]) begin miscompares++; $display("FAIL tb_start_r9: got %h want %h", v, m_regs[9]); end
    peek(4'd8, v);
    vectors++; if (v !== m_regs[8]) begin miscompares++; $display("FAIL tb_start_r8: got %h want %h", v, m_regs[8]); end
    set_req(3'd7, 4'd0, 4'd0, 4'd10, 1'b1, 32'h5A);
    bus_if.start = 1'b1;
    tick();
    dones = 0; last = 0; first = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (bus_if.done) begin
        if (dones == 0) first = i;
        else begin
          vectors++; if (i - last !== 4) begin miscompares++; $display("FAIL b2b_gap: got %0d want 4", i - last); end
        end
        dones++; last = i;
      end
    end
    bus_if.start = 1'b0;
    repeat (5) tick();
    m_regs[10] = 32'h5A; m_lo = 32'h5A;
    vectors++; if (dones !== 4) begin miscompares++; $display("FAIL b2b_count: got %0d want 4", dones); end
    vectors++; if (first !== 3) begin miscompares++; $display("FAIL b2b_first: got %0d want 3", first); end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    logic [63:0] z;
    for (int k = 0; k < 2; k++) begin
      set_req(3'd7, 4'd0, 4'd0, 4'd5, 1'b1, 32'd7);
      bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
      tick();
      tick();
      wr_en = 1'b1; wr_addr = (k == 0) ? 4'd5 : 4'd6; wr_data = 32'd9;
      tick();
      wr_en = 1'b0;
      vectors++; if (bus_if.done !== 1'b1) begin miscompares++; $display("FAIL coll_done: got %b want 1", bus_if.done); end
      if (k == 1) m_regs[6] = 32'd9;
      m_regs[5] = 32'd7; m_lo = 32'd7;
      peek(wr_addr, v);
      vectors++; if (v !== m_regs[wr_addr]) begin miscompares++; $display("FAIL coll_r%0d: got %h want %h", wr_addr, v, m_regs[wr_addr]); end
    end
    ext_write(4'd8, 32'h100);
    z = ref_alu(3'd0, m_regs[8], 32'd0);
    set_req(3'd0, 4'd8, 4'd0, 4'd9, 1'b0, 32'd0);
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd8; wr_data = 32'h200;
    tick();
    wr_en = 1'b0;
    m_regs[8] = 32'h200;
    repeat (2) tick();
    model_commit(3'd0, 4'd9, z);
    peek(4'd9, v);
    vectors++; if (v !== m_regs[9]) begin miscompares++; $display("FAIL ta_write_y: got %h want %h", v, m_regs[9]); end
    peek(4'd8, v);
    vectors++; if (v !== m_regs[8]) begin miscompares++; $display("FAIL ta_write_r8: got %h want %h", v, m_regs[8]); end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [2:0]  op;
    logic [3:0]  rd;
    logic [31:0] imm;
    int          lat;
    for (int i = 1; i < 16; i++) ext_write(4'(i), $urandom);
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) ext_write(4'($urandom_range(0, 15)), $urandom);
      op  = 3'($urandom_range(0, 7));
      rd  = 4'($urandom_range(0, 15));
      imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      run_op(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), rd, 1'($urandom_range(0, 1)), imm, lat);
      vectors++; if (lat !== 4) begin miscompares++; $display("FAIL rnd_latency[%0d]: got %0d want 4", n, lat); end
      vectors++; if (bus_if.result_lo !== m_lo) begin miscompares++; $display("FAIL rnd_lo[%0d] op%0d: got %h want %h", n, op, bus_if.result_lo, m_lo); end
      vectors++; if (bus_if.result_hi !== m_hi) begin miscompares++; $display("FAIL rnd_hi[%0d] op%0d: got %h want %h", n, op, bus_if.result_hi, m_hi); end
      peek(rd, v);
      vectors++; if (v !== m_regs[rd]) begin miscompares++; $display("FAIL rnd_rd[%0d] op%0d r%0d: got %h want %h", n, op, rd, v, m_regs[rd]); end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    clear = 1'b0;
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 32'd0; dbg_addr = 4'd0;
    bus_if.start = 1'b0;
    set_req(3'd0, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0);
    for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    test_reset();
    test_add_carry();
    test_mul();
    test_shift_sub();
    test_handshake();
    test_collision();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
